// File: rtl/vliw_regfile.sv
// ----------------------------------------------------------------------------
// vliw_regfile
//
// Shared integer register file for the STARBUG VLIW lanes.
// Each cycle it serves LANES lanes. Every lane gets two combinational reads
// (a1/a2 -> rd1/rd2) and one clocked write (we3/a3/wd3). Lane 0 is the oldest
// slot in the bundle.
//
// Write collisions are resolved in bundle order: the highest-index lane wins.
// A cycle with a collision is counted for the hazard/performance logic.
//
// Parameters
//   XLEN         register width
//   E_SUPPORTED  1: RV32E (x1..x15 stored, any address with bit4 set is illegal)
//   LANES        number of issue lanes (1..4)
//   CNTW         width of the saturating conflict counter
//
// Ports
//   clk            clock, all state updates on posedge
//   reset          asynchronous, active-low reset
//   a1, a2         lane i read addresses at [5i+:5]
//   rd1, rd2       lane i read data at [XLEN*i+:XLEN]
//   we3, a3, wd3   lane i write enable / address / data
//   ConflictW      registered flag: the previous cycle had >=2 enabled writes
//                  to the same nonzero register
//   ConflictCount  saturating count of conflict cycles
//   ClrConflict    synchronous clear of ConflictCount and ConflictW
//
// Build option
//   VLIW_RF_BYPASS_EN  when defined, a read returns same-cycle write data
//                      (0-cycle RAW). When undefined, a write becomes visible
//                      on the following cycle.
// ----------------------------------------------------------------------------
module vliw_regfile #(
    parameter int XLEN        = 32,
    parameter bit E_SUPPORTED = 1'b0,
    parameter int LANES       = 4,
    parameter int CNTW        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LANES*5-1:0]    a1,
    input  logic [LANES*5-1:0]    a2,
    output logic [LANES*XLEN-1:0] rd1,
    output logic [LANES*XLEN-1:0] rd2,
    input  logic [LANES-1:0]      we3,
    input  logic [LANES*5-1:0]    a3,
    input  logic [LANES*XLEN-1:0] wd3,
    output logic                  ConflictW,
    output logic [CNTW-1:0]       ConflictCount,
    input  logic                  ClrConflict
);

    localparam int NREGS = E_SUPPORTED ? 16 : 32;

    // x0 is never stored, so the array starts at index 1
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];
    logic            conflict_s;
    logic            conflict_w_q;
    logic            conflict_w_d;
    logic [CNTW-1:0] conflict_cnt_q;
    logic [CNTW-1:0] conflict_cnt_d;

    // An address names a stored register: it is not x0, and on RV32E it is not
    // in the upper half.
    function automatic logic addr_legal(input logic [4:0] a);
        return (a != 5'd0) && !(E_SUPPORTED && a[4]);
    endfunction

    // Read one port. Reset forces 0 so that a write held during reset cannot
    // leak through the bypass path.
    function automatic logic [XLEN-1:0] rd_lookup(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        for (int r = 1; r < NREGS; r++) begin
            v = (a == r[4:0]) ? regs_q[r] : v;
        end
`ifdef VLIW_RF_BYPASS_EN
        // Ascending lane order, so the youngest matching write wins
        for (int l = 0; l < LANES; l++) begin
            v = (we3[l] && (a3[5*l +: 5] == a)) ? wd3[XLEN*l +: XLEN] : v;
        end
`endif
        return (reset && addr_legal(a)) ? v : '0;
    endfunction

    // Next storage contents: later lanes override earlier ones for the same
    // register. Writes to x0 or to RV32E-illegal addresses match no entry and
    // are dropped.
    always_comb begin
        for (int r = 1; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
            for (int l = 0; l < LANES; l++) begin
                regs_d[r] = (we3[l] && (a3[5*l +: 5] == r[4:0]))
                          ? wd3[XLEN*l +: XLEN] : regs_d[r];
            end
        end
    end

    // Register storage with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Detect any pair of enabled writes to the same nonzero address
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                conflict_s = conflict_s
                           | (we3[i] & we3[j]
                              & (a3[5*i +: 5] == a3[5*j +: 5])
                              & (a3[5*i +: 5] != 5'd0));
            end
        end
    end

    // Conflict flag and saturating counter next state; the clear wins over a
    // coincident conflict
    always_comb begin
        conflict_w_d   = 1'b0;
        conflict_cnt_d = conflict_cnt_q;
        if (ClrConflict) begin
            conflict_w_d   = 1'b0;
            conflict_cnt_d = '0;
        end else if (conflict_s && (conflict_cnt_q != {CNTW{1'b1}})) begin
            conflict_w_d   = 1'b1;
            conflict_cnt_d = conflict_cnt_q + CNTW'(1);
        end else begin
            conflict_w_d   = conflict_s;
            conflict_cnt_d = conflict_cnt_q;
        end
    end

    // Conflict flag and counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflict_w_q   <= 1'b0;
            conflict_cnt_q <= '0;
        end else begin
            conflict_w_q   <= conflict_w_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Per-lane read ports
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int l = 0; l < LANES; l++) begin
            rd1[XLEN*l +: XLEN] = rd_lookup(a1[5*l +: 5]);
            rd2[XLEN*l +: XLEN] = rd_lookup(a2[5*l +: 5]);
        end
    end

    assign ConflictW     = conflict_w_q;
    assign ConflictCount = conflict_cnt_q;

endmodule

// File: tb/tb_vliw_regfile.sv
// ----------------------------------------------------------------------------
// tb_vliw_regfile
//
// Drives two register-file instances with the same stimulus:
//   dut_a  RV32I, CNTW=16
//   dut_b  RV32E, CNTW=2
// A behavioural model keeps a plain register array and counters for each
// instance. The model is compared with the outputs on every falling edge.
// Directed checks with literal expected values also pin the model.
// ----------------------------------------------------------------------------
module tb_vliw_regfile;

    localparam int XLEN  = 32;
    localparam int LANES = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [LANES*5-1:0]    a1, a2, a3;
    logic [LANES-1:0]      we3;
    logic [LANES*XLEN-1:0] wd3;
    logic                  clr;
    logic [LANES*XLEN-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic                  cw_a, cw_b;
    logic [15:0]           cnt_a;
    logic [1:0]            cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    vliw_regfile #(.XLEN(XLEN), .E_SUPPORTED(1'b0), .LANES(LANES), .CNTW(16)) dut_a (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_a), .rd2(rd2_a),
        .we3(we3), .a3(a3), .wd3(wd3), .ConflictW(cw_a), .ConflictCount(cnt_a),
        .ClrConflict(clr)
    );

    vliw_regfile #(.XLEN(XLEN), .E_SUPPORTED(1'b1), .LANES(LANES), .CNTW(2)) dut_b (
        .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
        .we3(we3), .a3(a3), .wd3(wd3), .ConflictW(cw_b), .ConflictCount(cnt_b),
        .ClrConflict(clr)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: index 0 follows dut_a, index 1 follows dut_b
    // ------------------------------------------------------------------
    logic [XLEN-1:0] m_regs [2][32];
    int              m_cnt  [2];
    bit              m_cw   [2];

    function automatic int cmax(int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    function automatic bit m_legal(int k, logic [4:0] a);
        return (a != 5'd0) && !(k == 1 && a >= 5'd16);
    endfunction

    function automatic bit m_conflict();
        bit c;
        c = 1'b0;
        for (int i = 0; i < LANES; i++)
            for (int j = i + 1; j < LANES; j++)
                if (we3[i] && we3[j] && a3[5*i +: 5] == a3[5*j +: 5] && a3[5*i +: 5] != 5'd0)
                    c = 1'b1;
        return c;
    endfunction

    function automatic logic [XLEN-1:0] m_read(int k, logic [4:0] a);
        logic [XLEN-1:0] v;
        if (!reset || !m_legal(k, a)) return '0;
        v = m_regs[k][a];
`ifdef VLIW_RF_BYPASS_EN
        for (int l = 0; l < LANES; l++)
            if (we3[l] && a3[5*l +: 5] == a) v = wd3[XLEN*l +: XLEN];
`endif
        return v;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 32; r++) m_regs[k][r] <= '0;
                m_cnt[k] <= 0;
                m_cw[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int l = 0; l < LANES; l++)
                    if (we3[l] && m_legal(k, a3[5*l +: 5]))
                        m_regs[k][a3[5*l +: 5]] <= wd3[XLEN*l +: XLEN];
                m_cw[k]  <= clr ? 1'b0 : m_conflict();
                m_cnt[k] <= clr ? 0 :
                            ((m_conflict() && m_cnt[k] < cmax(k)) ? m_cnt[k] + 1 : m_cnt[k]);
            end
        end
    end

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances with the model on each falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int l = 0; l < LANES; l++) begin
                cmp($sformatf("rd1_a[%0d]", l), rd1_a[XLEN*l +: XLEN], m_read(0, a1[5*l +: 5]));
                cmp($sformatf("rd2_a[%0d]", l), rd2_a[XLEN*l +: XLEN], m_read(0, a2[5*l +: 5]));
                cmp($sformatf("rd1_b[%0d]", l), rd1_b[XLEN*l +: XLEN], m_read(1, a1[5*l +: 5]));
                cmp($sformatf("rd2_b[%0d]", l), rd2_b[XLEN*l +: XLEN], m_read(1, a2[5*l +: 5]));
            end
            cmp("cw_a",  {31'd0, cw_a},  {31'd0, m_cw[0]});
            cmp("cw_b",  {31'd0, cw_b},  {31'd0, m_cw[1]});
            cmp("cnt_a", {16'd0, cnt_a}, 32'(m_cnt[0]));
            cmp("cnt_b", {30'd0, cnt_b}, 32'(m_cnt[1]));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        we3 = '0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0; clr = 1'b0;
    endtask

    task automatic set_wr(int l, logic [4:0] a, logic [31:0] d);
        we3[l] = 1'b1;
        a3[5*l +: 5] = a;
        wd3[XLEN*l +: XLEN] = d;
    endtask

    task automatic set_rd(int l, logic [4:0] ra1, logic [4:0] ra2);
        a1[5*l +: 5] = ra1;
        a2[5*l +: 5] = ra2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_b [5] = '{1, 2, 3, 3, 3};
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        chk_en = 1'b1;

        // A write held during reset is ignored; x5 reads 0
        set_wr(0, 5'd5, 32'hA5);
        for (int l = 0; l < LANES; l++) set_rd(l, 5'd5, 5'd0);
        @(negedge clk);
        cmp("x5_in_reset", rd1_a[31:0], 32'h0);
        tick();
        reset = 1'b1;
        tick();
        we3 = '0;
        @(negedge clk);
        for (int l = 0; l < LANES; l++) cmp("x5_after_wr", rd1_a[XLEN*l +: XLEN], 32'hA5);
        tick();

        // Collision on x7: lane 3 wins and one conflict cycle is counted
        clear_inputs();
        set_wr(1, 5'd7, 32'h11);
        set_wr(3, 5'd7, 32'h33);
        set_rd(0, 5'd7, 5'd7);
        tick();
        we3 = '0;
        @(negedge clk);
        cmp("x7_winner", rd1_a[31:0], 32'h33);
        cmp("cw_set",    {31'd0, cw_a}, 32'd1);
        cmp("cnt_one",   {16'd0, cnt_a}, 32'd1);
        tick();
        @(negedge clk);
        cmp("cw_drop",   {31'd0, cw_a}, 32'd0);
        cmp("cnt_hold",  {16'd0, cnt_a}, 32'd1);
        tick();

        // Two writes to x0 are dropped and do not count as a conflict
        clear_inputs();
        set_wr(0, 5'd0, 32'hFF);
        set_wr(2, 5'd0, 32'hFF);
        tick();
        we3 = '0;
        @(negedge clk);
        cmp("x0_zero",   rd1_a[31:0], 32'h0);
        cmp("x0_no_cw",  {31'd0, cw_a}, 32'd0);
        cmp("x0_no_cnt", {16'd0, cnt_a}, 32'd1);
        tick();

        // Same-cycle write and read of x9
        clear_inputs();
        set_wr(0, 5'd9, 32'h10);
        tick();
        we3 = '0;
        set_wr(2, 5'd9, 32'h42);
        set_rd(1, 5'd0, 5'd9);
        @(negedge clk);
`ifdef VLIW_RF_BYPASS_EN
        cmp("x9_same_cycle", rd2_a[XLEN*1 +: XLEN], 32'h42);
`else
        cmp("x9_same_cycle", rd2_a[XLEN*1 +: XLEN], 32'h10);
`endif
        tick();
        we3 = '0;
        @(negedge clk);
        cmp("x9_next_cycle", rd2_a[XLEN*1 +: XLEN], 32'h42);
        tick();

        // Saturation of the 2-bit counter, then a clear that coincides with a conflict
        clear_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        set_wr(0, 5'd3, 32'h1);
        set_wr(1, 5'd3, 32'h2);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            cmp("cnt_b_sat", {30'd0, cnt_b}, 32'(exp_b[i]));
            cmp("cnt_a_run", {16'd0, cnt_a}, 32'(i + 1));
        end
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        we3 = '0;
        @(negedge clk);
        cmp("clr_cnt_b", {30'd0, cnt_b}, 32'd0);
        cmp("clr_cw_b",  {31'd0, cw_b},  32'd0);
        cmp("clr_cnt_a", {16'd0, cnt_a}, 32'd0);
        tick();

        // RV32E: x20 is illegal, so the write is dropped and the read returns 0
        clear_inputs();
        set_wr(0, 5'd20, 32'hDEAD);
        set_rd(0, 5'd20, 5'd0);
        @(negedge clk);
        cmp("e_x20_same", rd1_b[31:0], 32'h0);
        tick();
        we3 = '0;
        @(negedge clk);
        cmp("e_x20_read", rd1_b[31:0], 32'h0);
        cmp("i_x20_read", rd1_a[31:0], 32'hDEAD);
        tick();

        // Reset asserted mid-cycle with a write pending: the write is lost
        clear_inputs();
        set_wr(3, 5'd5, 32'h77);
        set_rd(0, 5'd5, 5'd5);
        #2 reset = 1'b0;
        @(negedge clk);
        cmp("rst_mid_read", rd1_a[31:0], 32'h0);
        tick();
        reset = 1'b1;
        we3 = '0;
        @(negedge clk);
        cmp("rst_wr_lost", rd1_a[31:0], 32'h0);
        tick();

        // Mixed traffic on all lanes, checked only against the model
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            for (int l = 0; l < LANES; l++) begin
                if ((i + l) % 3 != 0) set_wr(l, 5'((i * 7 + l * 3) % 32), 32'(i * 256 + l + 1));
                set_rd(l, 5'((i * 5 + l) % 32), 5'((i * 7 + l * 3 + 3) % 32));
            end
            tick();
        end
        clear_inputs();
        tick();
        tick();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
